// File: rtl/maze_stream_checker.sv
// Maze solver harness partner: streams a stored 15x15 maze out serially,
// then captures and checks the solver's path reply.
module maze_stream_checker #(
    parameter int TIMEOUT_CYC = 2048,
    parameter int MAX_LEN     = 225
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [3:0]  load_x,
    input  logic [14:0] load_row,
    input  logic        start,
    input  logic        expect_solvable,
    output logic        in_valid,
    output logic        maze,
    input  logic        out_valid,
    input  logic        maze_not_valid,
    input  logic [3:0]  out_x,
    input  logic [3:0]  out_y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [7:0]  path_len
);

    localparam int WCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT_CYC - 1);
    localparam logic [8:0] MLEN = 9'(MAX_LEN);

    localparam logic [2:0] E_TIMEOUT = 3'd1;
    localparam logic [2:0] E_WALL    = 3'd2;
    localparam logic [2:0] E_ADJ     = 3'd3;
    localparam logic [2:0] E_START   = 3'd4;
    localparam logic [2:0] E_END     = 3'd5;
    localparam logic [2:0] E_VERDICT = 3'd6;
    localparam logic [2:0] E_LONG    = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        RECV,
        FIN
    } state_t;

    state_t state;

    // Entry 15 is never written; it keeps row indexing full-width.
    logic [14:0] rows [16];

    logic [3:0]     sx, sy;
    logic [3:0]     nx, ny;
    logic [WCW-1:0] wcnt;
    logic           exp_q;
    logic           nopath;
    logic [3:0]     px, py;
    logic           wall;
    logic           adj;
    logic [3:0]     dx, dy;
    logic           too_long;
    logic [2:0]     rep_err;
    logic [2:0]     fall_err;

    always_comb begin
        if (sy == 4'd14) begin
            nx = sx + 4'd1;
            ny = 4'd0;
        end else begin
            nx = sx;
            ny = sy + 4'd1;
        end

        wall = 1'b1;
        if (out_x < 4'd15 && out_y < 4'd15) begin
            wall = rows[out_x][out_y];
        end

        dx = (out_x > px) ? out_x - px : px - out_x;
        dy = (out_y > py) ? out_y - py : py - out_y;
        adj = ({1'b0, dx} + {1'b0, dy}) == 5'd1;

        too_long = {1'b0, path_len} >= MLEN;

        rep_err = 3'd0;
        if (state == WAIT) begin
            if (maze_not_valid) begin
                rep_err = exp_q ? E_VERDICT : 3'd0;
            end else if (out_x != 4'd13 || out_y != 4'd13) begin
                rep_err = E_START;
            end else if (wall) begin
                rep_err = E_WALL;
            end
        end else if (!nopath) begin
            if (wall) begin
                rep_err = E_WALL;
            end else if (!adj) begin
                rep_err = E_ADJ;
            end
        end

        fall_err = 3'd0;
        if (!nopath) begin
            if (px != 4'd1 || py != 4'd1) begin
                fall_err = E_END;
            end else if (!exp_q) begin
                fall_err = E_VERDICT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            for (int i = 0; i < 16; i++) begin
                rows[i] <= '0;
            end
            sx       <= '0;
            sy       <= '0;
            wcnt     <= '0;
            exp_q    <= 1'b0;
            nopath   <= 1'b0;
            px       <= '0;
            py       <= '0;
            in_valid <= 1'b0;
            maze     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= '0;
            path_len <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SEND;
                        busy     <= 1'b1;
                        pass     <= 1'b0;
                        err_code <= '0;
                        path_len <= '0;
                        exp_q    <= expect_solvable;
                        nopath   <= 1'b0;
                        sx       <= '0;
                        sy       <= '0;
                        in_valid <= 1'b1;
                        maze     <= rows[0][0];
                    end else if (load_en && load_x != 4'd15) begin
                        rows[load_x] <= load_row;
                    end
                end
                SEND: begin
                    if (sx == 4'd14 && sy == 4'd14) begin
                        in_valid <= 1'b0;
                        maze     <= 1'b0;
                        wcnt     <= '0;
                        state    <= WAIT;
                    end else begin
                        sx   <= nx;
                        sy   <= ny;
                        maze <= rows[nx][ny];
                    end
                end
                WAIT: begin
                    if (out_valid) begin
                        path_len <= 8'd1;
                        nopath   <= maze_not_valid;
                        px       <= out_x;
                        py       <= out_y;
                        err_code <= rep_err;
                        state    <= RECV;
                    end else if (wcnt == WLAST) begin
                        err_code <= E_TIMEOUT;
                        state    <= FIN;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                RECV: begin
                    if (out_valid) begin
                        if (path_len != 8'hff) begin
                            path_len <= path_len + 8'd1;
                        end
                        px <= out_x;
                        py <= out_y;
                        if (err_code == 3'd0) begin
                            if (rep_err != 3'd0) begin
                                err_code <= rep_err;
                            end else if (too_long) begin
                                err_code <= E_LONG;
                            end
                        end
                        if (too_long) begin
                            state <= FIN;
                        end
                    end else begin
                        if (err_code == 3'd0) begin
                            err_code <= fall_err;
                        end
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    pass  <= (err_code == 3'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_stream_checker.sv
// Randomised bench for maze_stream_checker: a maze/reply reference model
// predicts the streamed bits and the final verdict of every run.
module tb_maze_stream_checker;

    localparam int TO = 2048;
    localparam int ML = 225;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [3:0]  load_x;
    logic [14:0] load_row;
    logic        start;
    logic        expect_solvable;
    logic        in_valid;
    logic        maze;
    logic        out_valid;
    logic        maze_not_valid;
    logic [3:0]  out_x;
    logic [3:0]  out_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  err_code;
    logic [7:0]  path_len;

    maze_stream_checker #(
        .TIMEOUT_CYC(TO),
        .MAX_LEN(ML)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load_en(load_en),
        .load_x(load_x),
        .load_row(load_row),
        .start(start),
        .expect_solvable(expect_solvable),
        .in_valid(in_valid),
        .maze(maze),
        .out_valid(out_valid),
        .maze_not_valid(maze_not_valid),
        .out_x(out_x),
        .out_y(out_y),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_code(err_code),
        .path_len(path_len)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;
    bit mdl [15][15];
    int rq_x[$];
    int rq_y[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_wall(input int x, input int y);
        if (x > 14 || y > 14) return 1'b1;
        return mdl[x][y];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Walk the reply in arrival order and keep the first rule broken.
    function automatic void model(input bit exp_s, input bit nmv,
                                  output int e, output int len);
        int n;
        n = rq_x.size();
        e = 0;
        len = 0;
        if (n == 0) begin
            e = 1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            int c;
            c = 0;
            len = i + 1;
            if (i == 0) begin
                if (nmv) c = exp_s ? 6 : 0;
                else if (rq_x[0] != 13 || rq_y[0] != 13) c = 4;
                else if (m_wall(rq_x[0], rq_y[0])) c = 2;
            end else if (!nmv) begin
                if (m_wall(rq_x[i], rq_y[i])) c = 2;
                else if (iabs(rq_x[i] - rq_x[i-1]) +
                         iabs(rq_y[i] - rq_y[i-1]) != 1) c = 3;
            end
            if (e == 0) e = c;
            if (len > ML) begin
                if (e == 0) e = 7;
                return;
            end
        end
        if (!nmv && e == 0) begin
            if (rq_x[n-1] != 1 || rq_y[n-1] != 1) e = 5;
            else if (!exp_s) e = 6;
        end
    endfunction

    task automatic do_load(input int x, input logic [14:0] r);
        load_en  = 1'b1;
        load_x   = 4'(x);
        load_row = r;
        tick();
        load_en = 1'b0;
        if (x < 15) begin
            for (int y = 0; y < 15; y++) mdl[x][y] = r[y];
        end
    endtask

    task automatic load_l_maze();
        logic [14:0] r;
        for (int x = 0; x < 15; x++) begin
            r = '1;
            if (x == 1) r[13:1] = '0;
            if (x >= 1 && x <= 13) r[13] = 1'b0;
            do_load(x, r);
        end
    endtask

    task automatic build_lpath();
        rq_x.delete();
        rq_y.delete();
        for (int x = 13; x >= 1; x--) begin
            rq_x.push_back(x);
            rq_y.push_back(13);
        end
        for (int y = 12; y >= 1; y--) begin
            rq_x.push_back(1);
            rq_y.push_back(y);
        end
    endtask

    task automatic run_case(input string name, input bit exp_s,
                            input bit nmv, input bit lws);
        int e_exp;
        int l_exp;
        int nb;
        bit got;
        model(exp_s, nmv, e_exp, l_exp);
        expect_solvable = exp_s;
        start = 1'b1;
        if (lws) begin
            load_en  = 1'b1;
            load_x   = 4'($urandom_range(0, 14));
            load_row = 15'($urandom);
        end
        tick();
        start = 1'b0;
        load_en = 1'b0;
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_start: got %b want 1", name, busy);
        end
        nb = 0;
        for (int k = 0; k < 225; k++) begin
            if (in_valid !== 1'b1 || maze !== mdl[k/15][k%15]) nb++;
            load_en  = 1'b1;
            load_x   = 4'($urandom);
            load_row = 15'($urandom);
            tick();
        end
        load_en = 1'b0;
        n_total++;
        if (nb != 0 || in_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s stream: bad_bits=%0d in_valid_after=%b want 0/0",
                     name, nb, in_valid);
        end
        for (int i = 0; i < rq_x.size(); i++) begin
            out_valid      = 1'b1;
            maze_not_valid = nmv;
            out_x          = 4'(rq_x[i]);
            out_y          = 4'(rq_y[i]);
            tick();
        end
        out_valid = 1'b0;
        maze_not_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < TO + 300 && !got; c++) begin
            if (done === 1'b1) got = 1'b1;
            else tick();
        end
        n_total++;
        if (!got) begin
            n_bad++;
            $display("FAIL %s done_seen: no done pulse, want one", name);
        end
        n_total++;
        if (err_code !== 3'(e_exp)) begin
            n_bad++;
            $display("FAIL %s err_code: got %0d want %0d", name, err_code, e_exp);
        end
        n_total++;
        if (pass !== (e_exp == 0)) begin
            n_bad++;
            $display("FAIL %s pass: got %b want %b", name, pass, e_exp == 0);
        end
        n_total++;
        if (path_len !== 8'(l_exp)) begin
            n_bad++;
            $display("FAIL %s path_len: got %0d want %0d", name, path_len, l_exp);
        end
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_end: got %b want 0", name, busy);
        end
        tick();
        n_total++;
        if (done !== 1'b0 || pass !== (e_exp == 0)) begin
            n_bad++;
            $display("FAIL %s done_pulse: done=%b pass=%b want 0/%b",
                     name, done, pass, e_exp == 0);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        load_en = 1'b0;
        load_x = '0;
        load_row = '0;
        start = 1'b0;
        expect_solvable = 1'b0;
        out_valid = 1'b0;
        maze_not_valid = 1'b0;
        out_x = '0;
        out_y = '0;
        for (int x = 0; x < 15; x++)
            for (int y = 0; y < 15; y++) mdl[x][y] = 1'b0;
        repeat (3) tick();
        n_total++;
        if ({in_valid, maze, busy, done, pass, err_code, path_len} !== '0) begin
            n_bad++;
            $display("FAIL reset: iv=%b mz=%b busy=%b done=%b pass=%b err=%0d len=%0d want all 0",
                     in_valid, maze, busy, done, pass, err_code, path_len);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle_ignore();
        out_valid = 1'b1;
        out_x = 4'd13;
        out_y = 4'd13;
        repeat (4) tick();
        out_valid = 1'b0;
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0 || path_len !== 8'd0) begin
            n_bad++;
            $display("FAIL idle_ignore: busy=%b done=%b len=%0d want 0/0/0",
                     busy, done, path_len);
        end
    endtask

    task automatic test_good_path();
        load_l_maze();
        build_lpath();
        run_case("good_path", 1'b1, 1'b0, 1'b0);
        run_case("good_path_lws", 1'b1, 1'b0, 1'b1);
        run_case("good_path_unexp", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_path_errors();
        build_lpath();
        rq_x.delete(1);
        rq_y.delete(1);
        run_case("not_adjacent", 1'b1, 1'b0, 1'b0);
        build_lpath();
        rq_x.delete(0);
        rq_y.delete(0);
        run_case("bad_start", 1'b1, 1'b0, 1'b0);
        build_lpath();
        void'(rq_x.pop_back());
        void'(rq_y.pop_back());
        run_case("bad_end", 1'b1, 1'b0, 1'b0);
        rq_x.push_back(2);
        rq_y.push_back(2);
        run_case("wall_hit", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_no_path();
        rq_x.delete();
        rq_y.delete();
        rq_x.push_back(0);
        rq_y.push_back(0);
        run_case("no_path_ok", 1'b0, 1'b1, 1'b0);
        run_case("no_path_wrong", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_too_long();
        rq_x.delete();
        rq_y.delete();
        for (int i = 0; i < ML + 1; i++) begin
            rq_x.push_back((i % 2 == 0) ? 13 : 12);
            rq_y.push_back(13);
        end
        run_case("too_long", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        rq_x.delete();
        rq_y.delete();
        run_case("timeout", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            int kind;
            int j;
            if ($urandom_range(0, 1) == 0) begin
                load_l_maze();
            end else begin
                for (int r = 0; r < 6; r++)
                    do_load($urandom_range(0, 15), 15'($urandom));
            end
            build_lpath();
            kind = $urandom_range(0, 3);
            if (kind == 1) begin
                j = $urandom_range(0, rq_x.size() - 1);
                rq_x[j] = $urandom_range(0, 15);
                rq_y[j] = $urandom_range(0, 15);
            end else if (kind == 2) begin
                j = $urandom_range(1, 24);
                while (rq_x.size() > j) begin
                    void'(rq_x.pop_back());
                    void'(rq_y.pop_back());
                end
            end else if (kind == 3) begin
                rq_x.delete();
                rq_y.delete();
                j = $urandom_range(1, 3);
                for (int i = 0; i < j; i++) begin
                    rq_x.push_back($urandom_range(0, 15));
                    rq_y.push_back($urandom_range(0, 15));
                end
            end
            run_case($sformatf("random%0d", it), 1'($urandom), kind == 3, 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        load_l_maze();
        expect_solvable = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        n_total++;
        if (in_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre: in_valid=%b want 1", in_valid);
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if (in_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: in_valid=%b busy=%b want 0/0", in_valid, busy);
        end
        for (int x = 0; x < 15; x++)
            for (int y = 0; y < 15; y++) mdl[x][y] = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        rq_x.delete();
        rq_y.delete();
        rq_x.push_back(5);
        rq_y.push_back(5);
        run_case("after_reset", 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_good_path();
        test_path_errors();
        test_no_path();
        test_too_long();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
